// File: rtl/rotozoom_frame_sequencer_pkg.sv
// Shared types and fixed-point helpers for the rotozoom per-frame parameter engine.
package rotozoom_frame_sequencer_pkg;

  localparam int UV_W   = 17;
  localparam int TRIG_W = 16;
  localparam int PROD_W = 2 * TRIG_W;
  localparam logic [7:0] QUAD_OFS = 8'd64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_MULTIPLY,
    ST_DRAIN,
    ST_COMMIT
  } state_e;

  // Tag routes each product to its shadow register.
  typedef enum logic [1:0] {
    TAG_P0,
    TAG_P1,
    TAG_P2,
    TAG_P3
  } tag_e;

  typedef struct packed {
    logic                     vld;
    tag_e                     tag;
    logic signed [TRIG_W-1:0] a;
    logic signed [TRIG_W-1:0] b;
  } mul_req_t;

  typedef struct packed {
    logic                     vld;
    tag_e                     tag;
    logic signed [PROD_W-1:0] p;
  } mul_rsp_t;

  // Floor-shift a product and keep the low uv bits (mod 2^17).
  function automatic logic [UV_W-1:0] fix_to_uv(input logic signed [PROD_W-1:0] p,
                                                input int                       shift);
    logic signed [PROD_W-1:0] s;
    s = p >>> shift;
    return s[UV_W-1:0];
  endfunction

endpackage

// File: rtl/rotozoom_frame_sequencer_mul16s.sv
// Pipelined signed 16x16 multiplier; valid and tag travel alongside the product.
module rz_mul16s
  import rotozoom_frame_sequencer_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  mul_req_t req,
  output mul_rsp_t rsp
);

  logic [MUL_LAT-1:0]             vld_pipe_q, vld_pipe_d;
  logic [MUL_LAT-1:0][1:0]        tag_pipe_q, tag_pipe_d;
  logic [MUL_LAT-1:0][PROD_W-1:0] prod_pipe_q, prod_pipe_d;
  logic signed [PROD_W-1:0]       prod_in;

  always_comb begin
    prod_in        = $signed(req.a) * $signed(req.b);
    vld_pipe_d[0]  = req.vld;
    tag_pipe_d[0]  = req.tag;
    prod_pipe_d[0] = prod_in;
    for (int k = 1; k < MUL_LAT; k++) begin
      vld_pipe_d[k]  = vld_pipe_q[k-1];
      tag_pipe_d[k]  = tag_pipe_q[k-1];
      prod_pipe_d[k] = prod_pipe_q[k-1];
    end
  end

  // Only the valid bits need reset; data stages are qualified by them.
  always_ff @(posedge clk) begin
    if (!rst_n) vld_pipe_q <= '0;
    else        vld_pipe_q <= vld_pipe_d;
    tag_pipe_q  <= tag_pipe_d;
    prod_pipe_q <= prod_pipe_d;
  end

  assign rsp.vld = vld_pipe_q[MUL_LAT-1];
  assign rsp.tag = tag_e'(tag_pipe_q[MUL_LAT-1]);
  assign rsp.p   = prod_pipe_q[MUL_LAT-1];

endmodule

// File: rtl/rotozoom_frame_sequencer.sv
// Per-frame rotozoom parameter engine: one shared sine-table port, one shared multiplier,
// atomic commit of u/v strides and line-start values after each vsync falling edge.
module rotozoom_frame_sequencer
  import rotozoom_frame_sequencer_pkg::*;
#(
  parameter int CENTRE_X  = 320,
  parameter int CENTRE_Y  = 240,
  parameter int SHIFT     = 21,
  parameter int TABLE_LAT = 1,
  parameter int MUL_LAT   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     vsync,
  output logic [7:0]               tbl_idx,
  input  logic signed [TRIG_W-1:0] tbl_val,
  output logic [8:0]               angle,
  output logic [UV_W-1:0]          u_stride,
  output logic [UV_W-1:0]          v_stride,
  output logic [UV_W-1:0]          u_start,
  output logic [UV_W-1:0]          v_start,
  output logic                     params_update,
  output logic                     busy,
  output logic                     overrun
);

  // Schedule, counted in cycles after the detected edge (cnt=1 is the first busy cycle).
  localparam logic [4:0] C_SCALE = 5'(1 + TABLE_LAT);
  localparam logic [4:0] C_COS   = 5'(2 + TABLE_LAT);
  localparam logic [4:0] C_SIN   = 5'(3 + TABLE_LAT);
  localparam logic [4:0] C_P0    = 5'(2 + TABLE_LAT);
  localparam logic [4:0] C_P1    = 5'(3 + TABLE_LAT);
  localparam logic [4:0] C_P2    = 5'(4 + TABLE_LAT);
  localparam logic [4:0] C_P3    = 5'(5 + TABLE_LAT);
  localparam logic [4:0] C_LOAD  = 5'(5 + TABLE_LAT + MUL_LAT);

  localparam logic signed [TRIG_W-1:0] CX = TRIG_W'(CENTRE_X);
  localparam logic signed [TRIG_W-1:0] CY = TRIG_W'(CENTRE_Y);

  state_e                   state_q, state_d;
  logic [4:0]               cnt_q, cnt_d;
  logic                     vsync_q;
  logic [8:0]               angle_q, angle_d;
  logic [7:0]               tbl_idx_q, tbl_idx_d;
  logic signed [TRIG_W-1:0] scale_q, scale_d, cos_q, cos_d, sin_q, sin_d;
  logic [2:0][UV_W-1:0]     sh_q, sh_d;
  logic [UV_W-1:0]          u_stride_q, u_stride_d, v_stride_q, v_stride_d;
  logic [UV_W-1:0]          u_start_q, u_start_d, v_start_q, v_start_d;
  logic                     overrun_q, overrun_d;
  logic                     edge_fall, busy_w;
  mul_req_t                 mul_req;
  mul_rsp_t                 mul_rsp;

  assign edge_fall = vsync_q & ~vsync;
  assign busy_w    = (state_q != ST_IDLE);

  rz_mul16s #(.MUL_LAT(MUL_LAT)) u_mul (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (mul_req),
    .rsp  (mul_rsp)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    angle_d    = angle_q;
    tbl_idx_d  = tbl_idx_q;
    scale_d    = scale_q;
    cos_d      = cos_q;
    sin_d      = sin_q;
    sh_d       = sh_q;
    u_stride_d = u_stride_q;
    v_stride_d = v_stride_q;
    u_start_d  = u_start_q;
    v_start_d  = v_start_q;
    overrun_d  = edge_fall & busy_w & enable;
    mul_req    = '0;

    if (busy_w) begin
      cnt_d = cnt_q + 5'd1;
      if (cnt_q == 5'd1) tbl_idx_d = angle_q[7:0] + QUAD_OFS;
      if (cnt_q == 5'd2) tbl_idx_d = angle_q[7:0];
      if (cnt_q == C_SCALE) scale_d = tbl_val;
      if (cnt_q == C_COS)   cos_d   = tbl_val;
      if (cnt_q == C_SIN)   sin_d   = tbl_val;
      // P0 takes cos straight off the table bus in the cycle it is captured.
      if (cnt_q == C_P0) mul_req = '{vld: 1'b1, tag: TAG_P0, a: scale_q, b: tbl_val};
      if (cnt_q == C_P1) mul_req = '{vld: 1'b1, tag: TAG_P1, a: CX,      b: cos_q};
      if (cnt_q == C_P2) mul_req = '{vld: 1'b1, tag: TAG_P2, a: scale_q, b: sin_q};
      if (cnt_q == C_P3) mul_req = '{vld: 1'b1, tag: TAG_P3, a: CY,      b: sin_q};
    end

    if (mul_rsp.vld) begin
      case (mul_rsp.tag)
        TAG_P0:  sh_d[0] = fix_to_uv(mul_rsp.p, SHIFT);
        TAG_P1:  sh_d[1] = UV_W'(-fix_to_uv(mul_rsp.p, SHIFT));
        TAG_P2:  sh_d[2] = fix_to_uv(mul_rsp.p, SHIFT);
        default: ;
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        if (edge_fall && enable) begin
          state_d   = ST_LOOKUP;
          cnt_d     = 5'd1;
          tbl_idx_d = angle_q[8:1];
        end
      end
      ST_LOOKUP:   if (cnt_q == 5'd3) state_d = ST_MULTIPLY;
      ST_MULTIPLY: if (cnt_q == C_P3) state_d = ST_DRAIN;
      ST_DRAIN: begin
        // P3 is still on the multiplier output here, so it bypasses its shadow.
        if (cnt_q == C_LOAD) begin
          state_d    = ST_COMMIT;
          u_stride_d = sh_q[0];
          u_start_d  = sh_q[1];
          v_stride_d = sh_q[2];
          v_start_d  = fix_to_uv(mul_rsp.p, SHIFT);
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
        angle_d = angle_q + 9'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      vsync_q    <= 1'b0;
      angle_q    <= '0;
      tbl_idx_q  <= '0;
      scale_q    <= '0;
      cos_q      <= '0;
      sin_q      <= '0;
      sh_q       <= '0;
      u_stride_q <= '0;
      v_stride_q <= '0;
      u_start_q  <= '0;
      v_start_q  <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      vsync_q    <= vsync;
      angle_q    <= angle_d;
      tbl_idx_q  <= tbl_idx_d;
      scale_q    <= scale_d;
      cos_q      <= cos_d;
      sin_q      <= sin_d;
      sh_q       <= sh_d;
      u_stride_q <= u_stride_d;
      v_stride_q <= v_stride_d;
      u_start_q  <= u_start_d;
      v_start_q  <= v_start_d;
      overrun_q  <= overrun_d;
    end
  end

  assign tbl_idx       = tbl_idx_q;
  assign angle         = angle_q;
  assign u_stride      = u_stride_q;
  assign v_stride      = v_stride_q;
  assign u_start       = u_start_q;
  assign v_start       = v_start_q;
  assign params_update = (state_q == ST_COMMIT);
  assign busy          = busy_w;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_rotozoom_frame_sequencer.sv
// Scoreboard bench: each started frame pushes its expected commit; the monitor pops on params_update.
module tb_rotozoom_frame_sequencer;

  localparam int CX  = 320;
  localparam int CY  = 240;
  localparam int SH  = 21;
  localparam int LAT = 9;

  logic               clk = 1'b0;
  logic               rst_n, enable, vsync;
  logic [7:0]         tbl_idx;
  logic signed [15:0] tbl_val = '0;
  logic [8:0]         angle;
  logic [16:0]        u_stride, v_stride, u_start, v_start;
  logic               params_update, busy, overrun;

  typedef struct {
    logic [16:0] us, vs, ust, vst;
    int          ang;
    int          c0;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tab[256];
  real  r;
  int   cyc = 0, n_chk = 0, n_pass = 0, upd_cnt = 0, ovr_cnt = 0, exp_angle = 0;

  rotozoom_frame_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .vsync        (vsync),
    .tbl_idx      (tbl_idx),
    .tbl_val      (tbl_val),
    .angle        (angle),
    .u_stride     (u_stride),
    .v_stride     (v_stride),
    .u_start      (u_start),
    .v_start      (v_start),
    .params_update(params_update),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) tbl_val <= 16'(tab[tbl_idx]);

  function automatic exp_t model(input int a, input int c0);
    exp_t   e;
    longint s, c, n, p;
    s = tab[(a >> 1) & 255];
    c = tab[(a + 64) & 255];
    n = tab[a & 255];
    p = (s * c) >>> SH;  e.us  = 17'(p);
    p = (CX * c) >>> SH; e.ust = 17'(-p);
    p = (s * n) >>> SH;  e.vs  = 17'(p);
    p = (CY * n) >>> SH; e.vst = 17'(p);
    e.ang = a;
    e.c0  = c0;
    return e;
  endfunction

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (overrun) ovr_cnt++;
    if (params_update) begin
      upd_cnt++;
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_update cyc=%0d angle=%0d", cyc, angle);
      end else begin
        mon_e = sb.pop_front();
        n_chk++; if (u_stride !== mon_e.us) $display("FAIL u_stride a=%0d got=%h exp=%h", mon_e.ang, u_stride, mon_e.us); else n_pass++;
        n_chk++; if (v_stride !== mon_e.vs) $display("FAIL v_stride a=%0d got=%h exp=%h", mon_e.ang, v_stride, mon_e.vs); else n_pass++;
        n_chk++; if (u_start !== mon_e.ust) $display("FAIL u_start a=%0d got=%h exp=%h", mon_e.ang, u_start, mon_e.ust); else n_pass++;
        n_chk++; if (v_start !== mon_e.vst) $display("FAIL v_start a=%0d got=%h exp=%h", mon_e.ang, v_start, mon_e.vst); else n_pass++;
        n_chk++; if (angle !== 9'(mon_e.ang)) $display("FAIL commit_angle got=%0d exp=%0d", angle, mon_e.ang); else n_pass++;
        n_chk++; if (cyc - mon_e.c0 != LAT) $display("FAIL latency a=%0d got=%0d exp=%0d", mon_e.ang, cyc - mon_e.c0, LAT); else n_pass++;
      end
    end
  end

  task automatic run_frame(input bit expect_commit);
    @(negedge clk) vsync = 1'b1;
    @(negedge clk) vsync = 1'b0;
    if (expect_commit) begin
      sb.push_back(model(exp_angle, cyc));
      exp_angle = (exp_angle + 1) % 512;
    end
    repeat (11) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; enable = 1'b1; vsync = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({tbl_idx, angle, u_stride, v_stride, u_start, v_start, params_update, busy, overrun} !== '0)
      $display("FAIL reset_outputs got idx=%h ang=%h us=%h vs=%h ust=%h vst=%h pu=%b b=%b o=%b exp all 0",
               tbl_idx, angle, u_stride, v_stride, u_start, v_start, params_update, busy, overrun);
    else n_pass++;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    n_chk++; if (upd_cnt != 0) $display("FAIL idle_no_update got=%0d exp=0", upd_cnt); else n_pass++;
    n_chk++; if ({angle, busy, u_start} !== '0) $display("FAIL idle_state angle=%0d busy=%b ust=%h exp 0", angle, busy, u_start); else n_pass++;
  endtask

  task automatic test_first_frame;
    run_frame(1'b1);
    n_chk++; if (sb.size() != 0) $display("FAIL first_commit_missing pending=%0d exp=0", sb.size()); else n_pass++;
    n_chk++; if (u_start !== 17'h1FFFC) $display("FAIL first_u_start got=%h exp=1fffc", u_start); else n_pass++;
    n_chk++; if ({u_stride, v_stride, v_start} !== '0) $display("FAIL first_zero us=%h vs=%h vst=%h exp 0", u_stride, v_stride, v_start); else n_pass++;
    n_chk++; if (angle !== 9'd1) $display("FAIL first_angle got=%0d exp=1", angle); else n_pass++;
  endtask

  task automatic test_angle_64;
    repeat (64) run_frame(1'b1);
    n_chk++; if (v_stride !== 17'd362) $display("FAIL a64_v_stride got=%0d exp=362", v_stride); else n_pass++;
    n_chk++; if (v_start !== 17'd3) $display("FAIL a64_v_start got=%0d exp=3", v_start); else n_pass++;
    n_chk++; if ({u_stride, u_start} !== '0) $display("FAIL a64_u got us=%h ust=%h exp 0", u_stride, u_start); else n_pass++;
    n_chk++; if (angle !== 9'd65) $display("FAIL a64_angle got=%0d exp=65", angle); else n_pass++;
  endtask

  task automatic test_angle_192;
    repeat (128) run_frame(1'b1);
    n_chk++; if (v_stride !== 17'h1FE95) $display("FAIL a192_v_stride got=%h exp=1fe95", v_stride); else n_pass++;
    n_chk++; if (v_start !== 17'h1FFFC) $display("FAIL a192_v_start got=%h exp=1fffc", v_start); else n_pass++;
    n_chk++; if (angle !== 9'd193) $display("FAIL a192_angle got=%0d exp=193", angle); else n_pass++;
  endtask

  task automatic test_overrun;
    int u0, o0;
    u0 = upd_cnt; o0 = ovr_cnt;
    @(negedge clk) vsync = 1'b1;
    @(negedge clk) vsync = 1'b0;
    sb.push_back(model(exp_angle, cyc));
    exp_angle = (exp_angle + 1) % 512;
    repeat (2) @(negedge clk); vsync = 1'b1;
    repeat (2) @(negedge clk); vsync = 1'b0;
    repeat (8) @(negedge clk);
    n_chk++; if (ovr_cnt - o0 != 1) $display("FAIL overrun_pulses got=%0d exp=1", ovr_cnt - o0); else n_pass++;
    n_chk++; if (upd_cnt - u0 != 1) $display("FAIL overrun_commits got=%0d exp=1", upd_cnt - u0); else n_pass++;
    n_chk++; if (angle !== 9'd194) $display("FAIL overrun_angle got=%0d exp=194", angle); else n_pass++;
  endtask

  task automatic test_wrap;
    repeat (318) run_frame(1'b1);
    n_chk++; if (angle !== 9'd0) $display("FAIL wrap_angle got=%0d exp=0", angle); else n_pass++;
    n_chk++; if (sb.size() != 0) $display("FAIL wrap_pending got=%0d exp=0", sb.size()); else n_pass++;
  endtask

  task automatic test_reset_abort;
    int u0;
    run_frame(1'b1);
    u0 = upd_cnt;
    @(negedge clk) vsync = 1'b1;
    @(negedge clk) vsync = 1'b0;
    repeat (5) @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk); rst_n = 1'b1;
    exp_angle = 0;
    repeat (12) @(negedge clk);
    n_chk++; if (upd_cnt != u0) $display("FAIL abort_update got=%0d exp=0", upd_cnt - u0); else n_pass++;
    n_chk++;
    if ({angle, u_stride, v_stride, u_start, v_start, busy} !== '0)
      $display("FAIL abort_outputs ang=%0d us=%h vs=%h ust=%h vst=%h busy=%b exp 0", angle, u_stride, v_stride, u_start, v_start, busy);
    else n_pass++;
  endtask

  task automatic test_enable;
    int u0;
    u0 = upd_cnt;
    enable = 1'b0;
    repeat (3) run_frame(1'b0);
    n_chk++; if (upd_cnt != u0 || angle !== 9'd0) $display("FAIL disabled_frames upd=%0d angle=%0d exp 0 0", upd_cnt - u0, angle); else n_pass++;
    enable = 1'b1;
    @(negedge clk) vsync = 1'b1;
    @(negedge clk) vsync = 1'b0;
    sb.push_back(model(exp_angle, cyc));
    exp_angle = (exp_angle + 1) % 512;
    repeat (3) @(negedge clk); enable = 1'b0;
    repeat (8) @(negedge clk);
    n_chk++; if (upd_cnt - u0 != 1 || angle !== 9'd1) $display("FAIL enable_drop upd=%0d angle=%0d exp 1 1", upd_cnt - u0, angle); else n_pass++;
    run_frame(1'b0);
    n_chk++; if (upd_cnt - u0 != 1 || angle !== 9'd1 || ovr_cnt != 1) $display("FAIL enable_off_edge upd=%0d angle=%0d ovr=%0d exp 1 1 1", upd_cnt - u0, angle, ovr_cnt); else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      r = 32767.0 * $sin(2.0 * 3.141592653589793 * i / 256.0);
      tab[i] = int'(r);
    end
    test_reset();
    test_first_frame();
    test_angle_64();
    test_angle_192();
    test_overrun();
    test_wrap();
    test_reset_abort();
    test_enable();
    n_chk++; if (sb.size() != 0) $display("FAIL final_pending got=%0d exp=0", sb.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
